ts_filter_table_ctrl: RTL and testbench

- Configuration sequencer for the 8192x1 PID filter table in the TS filter.
- Turns host commands into table write cycles: allow/block one PID, allow-all, block-all.
- After a bulk sweep, pulses the filter's FIFO-clear input so the filter resyncs against a consistent table.
- Sits between the host register/command interface and the table write port plus `fifo_aclr` of the TS filter.

---
 rtl/ts_filter_pkg.sv | 35 +++
 rtl/ts_filter_table_ctrl.sv | 118 +++++++++++
 tb/tb_ts_filter_table_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_filter_pkg.sv
// Shared encodings for the TS filter PID table and its configuration sequencer.
// Table bit 0 lets a PID through, 1 drops it.
package ts_filter_pkg;

  localparam int TS_PID_W = 13;
  localparam logic [TS_PID_W-1:0] TS_NULL_PID = 13'h1FFF;

  localparam logic TS_TBL_ALLOWED = 1'b0;
  localparam logic TS_TBL_BLOCKED = 1'b1;

  typedef enum logic [1:0] {
    TS_OP_BLOCK_PID = 2'd0,
    TS_OP_ALLOW_PID = 2'd1,
    TS_OP_BLOCK_ALL = 2'd2,
    TS_OP_ALLOW_ALL = 2'd3
  } ts_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_ONE,
    ST_SWEEP,
    ST_HOLD
  } ts_state_e;

  function automatic logic ts_op_data(input logic [1:0] op);
    if (op == TS_OP_ALLOW_PID || op == TS_OP_ALLOW_ALL)
      return TS_TBL_ALLOWED;
    return TS_TBL_BLOCKED;
  endfunction

  function automatic logic ts_op_single(input logic [1:0] op);
    return (op == TS_OP_BLOCK_PID) || (op == TS_OP_ALLOW_PID);
  endfunction

endpackage

// File: rtl/ts_filter_table_ctrl.sv
// Turns host allow/block commands into PID table write cycles and
// flushes the filter FIFO after a whole-table sweep.
module ts_filter_table_ctrl
  import ts_filter_pkg::*;
#(
  parameter int ADDR_W        = TS_PID_W,
  parameter int TABLE_DEPTH   = 2 ** ADDR_W,
  parameter int ACLR_HOLD     = 4,
  parameter int FLUSH_ON_BULK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_pid,
  output logic              cmd_ready,
  output logic [ADDR_W-1:0] table_wr_address,
  output logic              table_data,
  output logic              table_wren,
  output logic              filter_aclr,
  output logic              busy,
  output logic              done,
  output logic [7:0]        cfg_version
);

  localparam int HOLD_W = (ACLR_HOLD > 1) ? $clog2(ACLR_HOLD) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TABLE_DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ACLR_HOLD - 1);
  localparam logic FLUSH = (FLUSH_ON_BULK != 0);

  ts_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              data_d, wren_d, aclr_d, done_d;

  assign cmd_ready = (state_q == ST_IDLE);

  // The address register doubles as the sweep counter.
  always_comb begin
    state_d = state_q;
    addr_d  = table_wr_address;
    data_d  = table_data;
    hold_d  = hold_q;
    wren_d  = 1'b0;
    aclr_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          data_d = ts_op_data(cmd_op);
          wren_d = 1'b1;
          if (ts_op_single(cmd_op)) begin
            state_d = ST_WR_ONE;
            addr_d  = cmd_pid;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SWEEP;
            addr_d  = '0;
            done_d  = !FLUSH && (LAST == '0);
          end
        end
      end
      ST_WR_ONE: state_d = ST_IDLE;
      ST_SWEEP: begin
        if (table_wr_address == LAST) begin
          if (FLUSH) begin
            state_d = ST_HOLD;
            aclr_d  = 1'b1;
            hold_d  = HOLD_LOAD;
            done_d  = (HOLD_LOAD == '0);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          addr_d = table_wr_address + ADDR_W'(1);
          wren_d = 1'b1;
          done_d = !FLUSH && (addr_d == LAST);
        end
      end
      ST_HOLD: begin
        if (hold_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
          aclr_d = 1'b1;
          done_d = (hold_d == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      hold_q           <= '0;
      table_wr_address <= '0;
      table_data       <= 1'b0;
      table_wren       <= 1'b0;
      filter_aclr      <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      cfg_version      <= 8'd0;
    end else begin
      state_q          <= state_d;
      hold_q           <= hold_d;
      table_wr_address <= addr_d;
      table_data       <= data_d;
      table_wren       <= wren_d;
      filter_aclr      <= aclr_d;
      busy             <= (state_d != ST_IDLE);
      done             <= done_d;
      if (done_d)
        cfg_version <= cfg_version + 8'd1;
    end
  end

endmodule

// File: tb/tb_ts_filter_table_ctrl.sv
// Self-checking bench for ts_filter_table_ctrl with a table scoreboard
// built from the command semantics.
module tb_ts_filter_table_ctrl;

  localparam int AW = 13;
  localparam int DEPTH = 8192;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [AW-1:0] cmd_pid = '0;
  logic          cmd_ready;
  logic [AW-1:0] table_wr_address;
  logic          table_data;
  logic          table_wren;
  logic          filter_aclr;
  logic          busy;
  logic          done;
  logic [7:0]    cfg_version;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ver = 0;
  int n_viol = 0;
  bit model_tbl [DEPTH];
  bit obs_tbl [DEPTH];

  ts_filter_table_ctrl #(
    .ADDR_W(AW), .TABLE_DEPTH(DEPTH),
    .ACLR_HOLD(HOLD), .FLUSH_ON_BULK(1)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_pid(cmd_pid),
    .cmd_ready(cmd_ready),
    .table_wr_address(table_wr_address),
    .table_data(table_data), .table_wren(table_wren),
    .filter_aclr(filter_aclr), .busy(busy), .done(done),
    .cfg_version(cfg_version)
  );

  always #5 clk = ~clk;

  // Observed table plus illegal-write watch.
  always @(negedge clk) begin
    if (!reset) begin
      if (table_wren) obs_tbl[table_wr_address] = table_data;
      if (table_wren && (filter_aclr || cmd_ready)) n_viol++;
    end
  end

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [AW-1:0] pid);
    cmd_valid = v;
    cmd_op = op;
    cmd_pid = pid;
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [AW-1:0] pid);
    case (op)
      2'd0: model_tbl[pid] = 1'b1;
      2'd1: model_tbl[pid] = 1'b0;
      2'd2: foreach (model_tbl[i]) model_tbl[i] = 1'b1;
      default: foreach (model_tbl[i]) model_tbl[i] = 1'b0;
    endcase
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(0, 0, 0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({table_wren, filter_aclr, busy, done} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want 0000",
               {table_wren, filter_aclr, busy, done});
    end
    n_cmp++;
    if (table_wr_address !== '0 || table_data !== 1'b0 || cfg_version !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_regs got addr=%h data=%b ver=%0d want 0/0/0",
               table_wr_address, table_data, cfg_version);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready got ready=%b busy=%b want 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_single_allow;
    drive(1, 2'd1, 13'h0100);
    @(negedge clk);
    drive(0, 0, 0);
    model_apply(2'd1, 13'h0100);
    exp_ver++;
    n_cmp++;
    if (table_wren !== 1 || table_wr_address !== 13'h0100 || table_data !== 0 ||
        done !== 1 || cfg_version !== 8'(exp_ver) || cmd_ready !== 0) begin
      n_bad++;
      $display("FAIL single_write got wren=%b addr=%h data=%b done=%b ver=%0d rdy=%b want 1/0100/0/1/%0d/0",
               table_wren, table_wr_address, table_data, done, cfg_version,
               cmd_ready, exp_ver);
    end
    @(negedge clk);
    n_cmp++;
    if (table_wren !== 0 || done !== 0 || cmd_ready !== 1) begin
      n_bad++;
      $display("FAIL single_after got wren=%b done=%b rdy=%b want 0/0/1",
               table_wren, done, cmd_ready);
    end
  endtask

  task automatic test_block_all;
    int bad_i = -1;
    int bad_h = -1;
    drive(1, 2'd2, AW'($urandom));
    model_apply(2'd2, 0);
    @(negedge clk);
    drive(0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (bad_i < 0 && (table_wren !== 1 || table_wr_address !== i[AW-1:0] ||
          table_data !== 1 || done !== 0 || filter_aclr !== 0 || cmd_ready !== 0))
        bad_i = i;
      @(negedge clk);
    end
    n_cmp++;
    if (bad_i >= 0) begin
      n_bad++;
      $display("FAIL block_sweep first bad index %0d got addr=%h data=%b wren=%b want addr=%h data=1 wren=1",
               bad_i, table_wr_address, table_data, table_wren, bad_i);
    end
    for (int k = 0; k < HOLD; k++) begin
      if (bad_h < 0 && (filter_aclr !== 1 || table_wren !== 0 || busy !== 1 ||
          done !== (k == HOLD - 1)))
        bad_h = k;
      @(negedge clk);
    end
    exp_ver++;
    n_cmp++;
    if (bad_h >= 0) begin
      n_bad++;
      $display("FAIL block_hold bad at hold cycle %0d got aclr=%b wren=%b done=%b want 1/0/%b",
               bad_h, filter_aclr, table_wren, done, bad_h == HOLD - 1);
    end
    n_cmp++;
    if (filter_aclr !== 0 || busy !== 0 || done !== 0 || cmd_ready !== 1 ||
        cfg_version !== 8'(exp_ver)) begin
      n_bad++;
      $display("FAIL block_end got aclr=%b busy=%b done=%b rdy=%b ver=%0d want 0/0/0/1/%0d",
               filter_aclr, busy, done, cmd_ready, cfg_version, exp_ver);
    end
  endtask

  task automatic test_held_cmd;
    int bad_i = -1;
    int bad_h = -1;
    drive(1, 2'd3, 0);
    model_apply(2'd3, 0);
    @(negedge clk);
    drive(1, 2'd0, 13'h1FFF);
    for (int i = 0; i < DEPTH; i++) begin
      if (bad_i < 0 && (table_wren !== 1 || table_wr_address !== i[AW-1:0] ||
          table_data !== 0 || cmd_ready !== 0))
        bad_i = i;
      @(negedge clk);
    end
    n_cmp++;
    if (bad_i >= 0) begin
      n_bad++;
      $display("FAIL held_sweep first bad index %0d got addr=%h data=%b wren=%b want addr=%h data=0 wren=1",
               bad_i, table_wr_address, table_data, table_wren, bad_i);
    end
    for (int k = 0; k < HOLD; k++) begin
      if (bad_h < 0 && (filter_aclr !== 1 || table_wren !== 0 || cmd_ready !== 0))
        bad_h = k;
      @(negedge clk);
    end
    exp_ver++;
    n_cmp++;
    if (bad_h >= 0 || cmd_ready !== 1 || table_wren !== 0) begin
      n_bad++;
      $display("FAIL held_hold bad_h=%0d got rdy=%b wren=%b want -1/1/0",
               bad_h, cmd_ready, table_wren);
    end
    @(negedge clk);
    drive(0, 0, 0);
    model_apply(2'd0, 13'h1FFF);
    exp_ver++;
    n_cmp++;
    if (table_wren !== 1 || table_wr_address !== 13'h1FFF || table_data !== 1 ||
        done !== 1 || cfg_version !== 8'(exp_ver)) begin
      n_bad++;
      $display("FAIL held_write got wren=%b addr=%h data=%b done=%b ver=%0d want 1/1fff/1/1/%0d",
               table_wren, table_wr_address, table_data, done, cfg_version, exp_ver);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (table_wren !== 0 || cmd_ready !== 1) begin
      n_bad++;
      $display("FAIL held_once got wren=%b rdy=%b want 0/1", table_wren, cmd_ready);
    end
    begin
      int ones = 0;
      foreach (obs_tbl[i]) ones += obs_tbl[i];
      n_cmp++;
      if (ones !== 1 || obs_tbl[DEPTH-1] !== 1'b1) begin
        n_bad++;
        $display("FAIL held_table got ones=%0d top=%b want 1/1", ones, obs_tbl[DEPTH-1]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]    op [4];
    logic [AW-1:0] pid [4];
    foreach (op[k]) begin
      op[k] = 2'($urandom_range(0, 1));
      pid[k] = AW'($urandom);
    end
    @(negedge clk);
    drive(1, op[0], pid[0]);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      model_apply(op[k], pid[k]);
      exp_ver++;
      n_cmp++;
      if (table_wren !== 1 || table_wr_address !== pid[k] ||
          table_data !== (op[k] == 2'd0) || done !== 1 ||
          cfg_version !== 8'(exp_ver)) begin
        n_bad++;
        $display("FAIL b2b_write[%0d] got wren=%b addr=%h data=%b done=%b ver=%0d want 1/%h/%b/1/%0d",
                 k, table_wren, table_wr_address, table_data, done, cfg_version,
                 pid[k], op[k] == 2'd0, exp_ver);
      end
      if (k < 3) drive(1, op[k+1], pid[k+1]);
      else drive(0, 0, 0);
      @(negedge clk);
      n_cmp++;
      if (table_wren !== 0 || cmd_ready !== 1 || done !== 0) begin
        n_bad++;
        $display("FAIL b2b_gap[%0d] got wren=%b rdy=%b done=%b want 0/1/0",
                 k, table_wren, cmd_ready, done);
      end
    end
  endtask

  task automatic test_reset_mid_sweep;
    int bad_i = -1;
    logic [AW-1:0] p;
    drive(1, 2'd2, 0);
    @(negedge clk);
    drive(0, 0, 0);
    for (int i = 0; i <= 'h800; i++) begin
      if (bad_i < 0 && (table_wren !== 1 || table_wr_address !== i[AW-1:0] || done !== 0))
        bad_i = i;
      model_tbl[i] = 1'b1;
      if (i < 'h800) @(negedge clk);
    end
    n_cmp++;
    if (bad_i >= 0) begin
      n_bad++;
      $display("FAIL abort_sweep first bad index %0d got addr=%h want %h", bad_i,
               table_wr_address, bad_i);
    end
    #2 reset = 1'b1;
    #1;
    exp_ver = 0;
    n_cmp++;
    if (table_wren !== 0 || busy !== 0 || done !== 0 || filter_aclr !== 0 ||
        cfg_version !== 0 || table_wr_address !== 0 || cmd_ready !== 1) begin
      n_bad++;
      $display("FAIL abort_reset got wren=%b busy=%b done=%b aclr=%b ver=%0d addr=%h rdy=%b want 0/0/0/0/0/0/1",
               table_wren, busy, done, filter_aclr, cfg_version, table_wr_address,
               cmd_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    p = AW'($urandom);
    drive(1, 2'd0, p);
    @(negedge clk);
    drive(0, 0, 0);
    model_apply(2'd0, p);
    exp_ver++;
    n_cmp++;
    if (table_wren !== 1 || table_wr_address !== p || table_data !== 1 ||
        done !== 1 || cfg_version !== 8'd1) begin
      n_bad++;
      $display("FAIL abort_next got wren=%b addr=%h data=%b done=%b ver=%0d want 1/%h/1/1/1",
               table_wren, table_wr_address, table_data, done, cfg_version, p);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    logic [1:0] op;
    logic [AW-1:0] p;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_ver = 0;
    for (int k = 0; k < 256; k++) begin
      op = 2'($urandom_range(0, 1));
      p = AW'($urandom);
      drive(1, op, p);
      @(negedge clk);
      drive(0, 0, 0);
      model_apply(op, p);
      exp_ver = (exp_ver + 1) % 256;
      n_cmp++;
      if (done !== 1 || table_wr_address !== p || cfg_version !== 8'(exp_ver)) begin
        n_bad++;
        $display("FAIL wrap_op[%0d] got done=%b addr=%h ver=%0d want 1/%h/%0d",
                 k, done, table_wr_address, cfg_version, p, exp_ver);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (cfg_version !== 8'd0) begin
      n_bad++;
      $display("FAIL wrap_zero got ver=%0d want 0", cfg_version);
    end
  endtask

  task automatic test_table_final;
    int diff = 0;
    #1;
    foreach (model_tbl[i]) if (model_tbl[i] !== obs_tbl[i]) diff++;
    n_cmp++;
    if (diff !== 0) begin
      n_bad++;
      $display("FAIL table_scoreboard got %0d differing entries want 0", diff);
    end
    n_cmp++;
    if (n_viol !== 0) begin
      n_bad++;
      $display("FAIL wren_legal got %0d writes in IDLE/HOLD want 0", n_viol);
    end
  endtask

  initial begin
    test_reset;
    test_single_allow;
    test_block_all;
    test_held_cmd;
    test_back_to_back;
    test_reset_mid_sweep;
    test_wrap;
    test_table_final;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
